fixed_huff_token_enc: RTL and testbench

Pipelined fixed-Huffman (RFC 1951 BTYPE=01) token encoder for the DEFLATE compressor back end. It accepts one LZ77 token per beat: a literal byte, an end-of-block marker or a match length. Per beat it emits the bit-reversed Huffman code with the extra bits appended, plus the count of valid bits. It sits between the match finder and the bit packer, and replaces the single-range, no-handshake length encoder with a literal/length/EOB encoder that supports back-pressure.

---
 rtl/fixed_huff_token_enc_if.sv | 28 ++
 rtl/fixed_huff_token_enc.sv | 178 +++++++++++++++++
 tb/tb_fixed_huff_token_enc.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_huff_token_enc_if.sv
// fixed_huff_token_enc_if: token-in / code-out stream bundle for the fixed-Huffman encoder.
// master = upstream/downstream environment side, slave = encoder side.
interface fixed_huff_token_enc_if #(
    parameter int unsigned LEN_W  = 9,
    parameter int unsigned CODE_W = 13,
    parameter int unsigned CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [7:0]        in_lit;
    logic [LEN_W-1:0]  in_len;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [CNT_W-1:0]  out_nbits;
    logic              out_err;

    modport master (
        output in_valid, in_kind, in_lit, in_len, out_ready,
        input  in_ready, out_valid, out_code, out_nbits, out_err
    );

    modport slave (
        input  in_valid, in_kind, in_lit, in_len, out_ready,
        output in_ready, out_valid, out_code, out_nbits, out_err
    );
endinterface

// File: rtl/fixed_huff_token_enc.sv
// fixed_huff_token_enc: two-stage fixed-Huffman (DEFLATE BTYPE=01) literal/length/EOB encoder.
// Stage 1 maps the token to a Huffman code plus extra bits; stage 2 bit-reverses and packs.
// Build macro SLEN_FULL_RANGE_EN: when defined, match lengths 3..258 are legal; otherwise
// only 3..66 are legal and longer lengths produce an error beat.
module fixed_huff_token_enc #(
    parameter int unsigned LEN_W  = 9,
    parameter int unsigned CODE_W = 13,
    parameter int unsigned CNT_W  = 4
) (
    input logic                   clk,
    input logic                   rst,
    fixed_huff_token_enc_if.slave tok
);
    localparam logic [1:0] KindLit = 2'd0;
    localparam logic [1:0] KindLen = 2'd1;
    localparam logic [1:0] KindEob = 2'd2;

    logic s1_load, s2_load;

    // Stage 1 state: Huffman code (unreversed), its length, extra bits and their count
    logic       s1_valid_q;
    logic [8:0] s1_hcode_q;
    logic [3:0] s1_hlen_q;
    logic [4:0] s1_extra_q;
    logic [2:0] s1_nextra_q;
    logic       s1_err_q;

    logic [8:0] hcode_d;
    logic [3:0] hlen_d;
    logic [4:0] extra_d;
    logic [2:0] nextra_d;
    logic       err_d;

    logic [LEN_W-1:0] len_base, len_off;
    logic [8:0]       sym_base, sym;
    logic [2:0]       ne;

    // Stage 2 state: packed output beat
    logic              s2_valid_q;
    logic [CODE_W-1:0] s2_code_q;
    logic [CNT_W-1:0]  s2_nbits_q;
    logic              s2_err_q;

    logic [8:0]        rev;
    logic [CODE_W-1:0] code_d;
    logic [CNT_W-1:0]  nbits_d;

    assign s2_load       = !s2_valid_q || tok.out_ready;
    assign s1_load       = !s1_valid_q || s2_load;
    assign tok.in_ready  = s1_load;
    assign tok.out_valid = s2_valid_q;
    assign tok.out_code  = s2_code_q;
    assign tok.out_nbits = s2_nbits_q;
    assign tok.out_err   = s2_err_q;

    // Symbol map: token -> Huffman code, code length, extra bits
    always_comb begin
        hcode_d  = '0;
        hlen_d   = '0;
        extra_d  = '0;
        nextra_d = '0;
        err_d    = 1'b0;
        len_base = LEN_W'(3);
        sym_base = 9'd257;
        ne       = 3'd0;
        len_off  = '0;
        sym      = '0;
        unique case (tok.in_kind)
            KindLit: begin
                if (tok.in_lit < 8'd144) begin
                    hcode_d = 9'h030 + {1'b0, tok.in_lit};
                    hlen_d  = 4'd8;
                end else begin
                    hcode_d = 9'h190 + {1'b0, tok.in_lit - 8'd144};
                    hlen_d  = 4'd9;
                end
            end
            KindEob: hlen_d = 4'd7;
            KindLen: begin
                // Range select; 3..10 falls through to the defaults above
                if (tok.in_len < LEN_W'(3) || tok.in_len > LEN_W'(258)) begin
                    err_d = 1'b1;
`ifdef SLEN_FULL_RANGE_EN
                end else if (tok.in_len == LEN_W'(258)) begin
                    len_base = LEN_W'(258); sym_base = 9'd285; ne = 3'd0;
                end else if (tok.in_len >= LEN_W'(131)) begin
                    len_base = LEN_W'(131); sym_base = 9'd281; ne = 3'd5;
                end else if (tok.in_len >= LEN_W'(67)) begin
                    len_base = LEN_W'(67);  sym_base = 9'd277; ne = 3'd4;
`else
                end else if (tok.in_len > LEN_W'(66)) begin
                    err_d = 1'b1;
`endif
                end else if (tok.in_len >= LEN_W'(35)) begin
                    len_base = LEN_W'(35);  sym_base = 9'd273; ne = 3'd3;
                end else if (tok.in_len >= LEN_W'(19)) begin
                    len_base = LEN_W'(19);  sym_base = 9'd269; ne = 3'd2;
                end else if (tok.in_len >= LEN_W'(11)) begin
                    len_base = LEN_W'(11);  sym_base = 9'd265; ne = 3'd1;
                end
                len_off  = tok.in_len - len_base;
                sym      = sym_base + 9'(len_off >> ne);
                extra_d  = 5'(len_off) & ((5'd1 << ne) - 5'd1);
                nextra_d = ne;
`ifdef SLEN_FULL_RANGE_EN
                if (sym >= 9'd280) begin
                    hcode_d = 9'h0C0 + (sym - 9'd280);
                    hlen_d  = 4'd8;
                end else begin
                    hcode_d = sym - 9'd256;
                    hlen_d  = 4'd7;
                end
`else
                hcode_d = sym - 9'd256;
                hlen_d  = 4'd7;
`endif
                if (err_d) begin
                    hcode_d  = '0;
                    hlen_d   = '0;
                    extra_d  = '0;
                    nextra_d = '0;
                end
            end
            default: err_d = 1'b1;
        endcase
    end

    // Stage 1 register: captures a mapped token whenever the stage can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_hcode_q  <= '0;
            s1_hlen_q   <= '0;
            s1_extra_q  <= '0;
            s1_nextra_q <= '0;
            s1_err_q    <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= tok.in_valid;
            if (tok.in_valid) begin
                s1_hcode_q  <= hcode_d;
                s1_hlen_q   <= hlen_d;
                s1_extra_q  <= extra_d;
                s1_nextra_q <= nextra_d;
                s1_err_q    <= err_d;
            end
        end
    end

    // Pack: reverse the code over its own length, then append extra bits unreversed above it
    always_comb begin
        rev = '0;
        unique case (s1_hlen_q)
            4'd7: for (int i = 0; i < 7; i++) rev[i] = s1_hcode_q[6-i];
            4'd8: for (int i = 0; i < 8; i++) rev[i] = s1_hcode_q[7-i];
            4'd9: for (int i = 0; i < 9; i++) rev[i] = s1_hcode_q[8-i];
            default: rev = '0;
        endcase
        code_d  = CODE_W'(rev) | (CODE_W'(s1_extra_q) << s1_hlen_q);
        nbits_d = CNT_W'(s1_hlen_q) + CNT_W'(s1_nextra_q);
    end

    // Stage 2 register: output beat, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_code_q  <= '0;
            s2_nbits_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_code_q  <= code_d;
                s2_nbits_q <= nbits_d;
                s2_err_q   <= s1_err_q;
            end
        end
    end
endmodule

// File: tb/tb_fixed_huff_token_enc.sv
// tb_fixed_huff_token_enc: directed and streamed checks for fixed_huff_token_enc.
// Expectations follow SLEN_FULL_RANGE_EN the same way the design does.
module tb_fixed_huff_token_enc;
    localparam int unsigned LEN_W  = 9;
    localparam int unsigned CODE_W = 13;
    localparam int unsigned CNT_W  = 4;
`ifdef SLEN_FULL_RANGE_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif
    localparam logic [17:0] ERR_BEAT = {1'b1, 4'd0, 13'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    fixed_huff_token_enc_if #(.LEN_W(LEN_W), .CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

    fixed_huff_token_enc #(.LEN_W(LEN_W), .CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .tok (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: {err, nbits, code} built from the RFC 1951 length-base table
    function automatic logic [17:0] model(input logic [1:0] k, input logic [7:0] lit,
                                          input logic [LEN_W-1:0] len);
        int lbase [29];
        int ebits [29];
        int sym, hl, ne, ex, idx;
        logic [8:0]  hc;
        logic [12:0] code;
        lbase = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 15, 17, 19, 23, 27, 31, 35, 43, 51, 59,
                  67, 83, 99, 115, 131, 163, 195, 227, 258};
        ebits = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3,
                  4, 4, 4, 4, 5, 5, 5, 5, 0};
        ne = 0; ex = 0; idx = 0;
        if (k == 2'd3) return ERR_BEAT;
        if (k == 2'd0) sym = int'(lit);
        else if (k == 2'd2) sym = 256;
        else begin
            if (len < 3 || len > 258) return ERR_BEAT;
            if (!FULL && len > 66) return ERR_BEAT;
            for (int i = 0; i < 29; i++) if (int'(len) >= lbase[i]) idx = i;
            sym = 257 + idx;
            ne  = ebits[idx];
            ex  = int'(len) - lbase[idx];
        end
        if (sym < 144)      begin hc = 9'(48 + sym);        hl = 8; end
        else if (sym < 256) begin hc = 9'(400 + sym - 144); hl = 9; end
        else if (sym < 280) begin hc = 9'(sym - 256);       hl = 7; end
        else                begin hc = 9'(192 + sym - 280); hl = 8; end
        code = '0;
        for (int i = 0; i < hl; i++) code[hl-1-i] = hc[i];
        code = code | 13'(ex << hl);
        return {1'b0, 4'(hl + ne), code};
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_kind   = 2'd0;
        bus.in_lit    = 8'd0;
        bus.in_len    = '0;
        bus.out_ready = 1'b1;
    endtask

    // One token through an empty pipeline; returns the output beat and its latency in cycles
    task automatic run_token(input logic [1:0] k, input logic [7:0] lit,
                             input logic [LEN_W-1:0] len, output logic [17:0] got,
                             output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_kind = k; bus.in_lit = lit; bus.in_len = len;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        #1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk); #1; lat++;
        end
        got = {bus.out_err, bus.out_nbits, bus.out_code};
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_in_reset_valid: got %b want 0", bus.out_valid);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.out_code !== 13'd0) $display("FAIL reset_code: got %h want 0", bus.out_code);
        else n_pass++;
        n_checks++;
        if (bus.out_nbits !== 4'd0) $display("FAIL reset_nbits: got %0d want 0", bus.out_nbits);
        else n_pass++;
        n_checks++;
        if (bus.out_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.out_err);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_literals();
        logic [7:0]  lits [5] = '{8'h41, 8'hFF, 8'h00, 8'd143, 8'd144};
        logic [17:0] exp  [5] = '{{1'b0, 4'd8, 13'h08E}, {1'b0, 4'd9, 13'h1FF},
                                  {1'b0, 4'd8, 13'h00C}, {1'b0, 4'd8, 13'h0FD},
                                  {1'b0, 4'd9, 13'h013}};
        logic [17:0] got;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_token(2'd0, lits[i], '0, got, lat);
            n_checks++;
            if (got !== exp[i])
                $display("FAIL literal_%h: got err/nbits/code %b/%0d/%h want %b/%0d/%h", lits[i],
                         got[17], got[16:13], got[12:0], exp[i][17], exp[i][16:13], exp[i][12:0]);
            else n_pass++;
            n_checks++;
            if (lat !== 2) $display("FAIL literal_latency: got %0d want 2", lat);
            else n_pass++;
        end
    endtask

    task automatic test_lengths();
        logic [1:0]       kinds [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        logic [LEN_W-1:0] lens  [6] = '{9'd3, 9'd20, 9'd10, 9'd11, 9'd66, 9'd0};
        logic [17:0]      exp   [6] = '{{1'b0, 4'd7, 13'h040}, {1'b0, 4'd9, 13'h0D8},
                                        {1'b0, 4'd7, 13'h008}, {1'b0, 4'd8, 13'h048},
                                        {1'b0, 4'd10, 13'h394}, {1'b0, 4'd7, 13'h000}};
        logic [17:0] got;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_token(kinds[i], 8'd0, lens[i], got, lat);
            n_checks++;
            if (got !== exp[i])
                $display("FAIL length_k%0d_%0d: got err/nbits/code %b/%0d/%h want %b/%0d/%h",
                         kinds[i], lens[i], got[17], got[16:13], got[12:0],
                         exp[i][17], exp[i][16:13], exp[i][12:0]);
            else n_pass++;
            n_checks++;
            if (lat !== 2) $display("FAIL length_latency: got %0d want 2", lat);
            else n_pass++;
        end
    endtask

    task automatic test_full_range();
        logic [LEN_W-1:0] lens [4] = '{9'd100, 9'd258, 9'd257, 9'd67};
`ifdef SLEN_FULL_RANGE_EN
        logic [17:0] exp [4] = '{{1'b0, 4'd11, 13'h00F4}, {1'b0, 4'd8, 13'h00A3},
                                 {1'b0, 4'd13, 13'h1E23}, {1'b0, 4'd11, 13'h0054}};
`else
        logic [17:0] exp [4] = '{ERR_BEAT, ERR_BEAT, ERR_BEAT, ERR_BEAT};
`endif
        logic [17:0] got;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_token(2'd1, 8'd0, lens[i], got, lat);
            n_checks++;
            if (got !== exp[i])
                $display("FAIL long_length_%0d: got err/nbits/code %b/%0d/%h want %b/%0d/%h",
                         lens[i], got[17], got[16:13], got[12:0],
                         exp[i][17], exp[i][16:13], exp[i][12:0]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        logic [1:0]       kinds [5] = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd0};
        logic [LEN_W-1:0] lens  [5] = '{9'd2, 9'd10, 9'd259, 9'd0, 9'd0};
        logic [7:0]       lits  [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'h41};
        logic [17:0]      exp   [5] = '{ERR_BEAT, ERR_BEAT, ERR_BEAT, ERR_BEAT,
                                        {1'b0, 4'd8, 13'h08E}};
        logic [17:0] got;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_token(kinds[i], lits[i], lens[i], got, lat);
            n_checks++;
            if (got !== exp[i])
                $display("FAIL error_case_%0d: got err/nbits/code %b/%0d/%h want %b/%0d/%h", i,
                         got[17], got[16:13], got[12:0], exp[i][17], exp[i][16:13], exp[i][12:0]);
            else n_pass++;
        end
    endtask

    // Fill both stages under stall, hold, then pop and push in the same cycle
    task automatic test_stall();
        logic [17:0] a = {1'b0, 4'd8, 13'h08E};
        logic [17:0] b = {1'b0, 4'd7, 13'h040};
        logic [17:0] c = {1'b0, 4'd7, 13'h000};
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_kind = 2'd0; bus.in_lit = 8'h41;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL stall_ready_empty: got %b want 1", bus.in_ready);
        else n_pass++;
        @(negedge clk);
        bus.in_kind = 2'd1; bus.in_len = 9'd3;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL stall_ready_s1full: got %b want 1", bus.in_ready);
        else n_pass++;
        @(negedge clk);
        bus.in_kind = 2'd2;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_ready_full: got %b want 0", bus.in_ready);
        else n_pass++;
        n_checks++;
        if ({bus.out_valid, bus.out_err, bus.out_nbits, bus.out_code} !== {1'b1, a})
            $display("FAIL stall_first_beat: got v/beat %b/%h want 1/%h", bus.out_valid,
                     {bus.out_err, bus.out_nbits, bus.out_code}, a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({bus.out_valid, bus.out_err, bus.out_nbits, bus.out_code} !== {1'b1, a})
            $display("FAIL stall_hold: got v/beat %b/%h want 1/%h", bus.out_valid,
                     {bus.out_err, bus.out_nbits, bus.out_code}, a);
        else n_pass++;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL stall_pop_push: got %b want 1", bus.in_ready);
        else n_pass++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_err, bus.out_nbits, bus.out_code} !== {1'b1, b})
            $display("FAIL stall_second_beat: got v/beat %b/%h want 1/%h", bus.out_valid,
                     {bus.out_err, bus.out_nbits, bus.out_code}, b);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({bus.out_valid, bus.out_err, bus.out_nbits, bus.out_code} !== {1'b1, c})
            $display("FAIL stall_third_beat: got v/beat %b/%h want 1/%h", bus.out_valid,
                     {bus.out_err, bus.out_nbits, bus.out_code}, c);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL stall_drained: got %b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [17:0] got;
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_kind = 2'd0; bus.in_lit = 8'h10;
        @(negedge clk);
        bus.in_lit = 8'h20;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL midreset_full: got %b want 1", bus.out_valid);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_err, bus.out_nbits, bus.out_code} !== 19'd0)
            $display("FAIL midreset_clear: got v/beat %b/%h want 0/0", bus.out_valid,
                     {bus.out_err, bus.out_nbits, bus.out_code});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        run_token(2'd0, 8'hFF, '0, got, lat);
        n_checks++;
        if (got !== {1'b0, 4'd9, 13'h1FF})
            $display("FAIL midreset_first_token: got %h want %h", got, {1'b0, 4'd9, 13'h1FF});
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL midreset_latency: got %0d want 2", lat);
        else n_pass++;
    endtask

    // Streamed tokens against the model with random valid/ready; optional throughput check
    task automatic test_stream(input int n, input int rdy_pct, input int vld_pct,
                               input bit chk_rate);
        logic [17:0] q [$];
        logic [17:0] exp_v, cur, held;
        int sent = 0, cycles = 0, limit, r;
        bit pend = 1'b0, hold = 1'b0, stalled = 1'b0;
        limit = 20 * n + 50;
        bus.in_valid = 1'b0;
        while ((sent < n || q.size() != 0) && cycles < limit) begin
            @(negedge clk);
            cycles++;
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            if (!pend && sent < n && $urandom_range(99) < vld_pct) begin
                r = $urandom_range(15);
                bus.in_kind = (r < 7) ? 2'd0 : (r < 14) ? 2'd1 : (r == 14) ? 2'd2 : 2'd3;
                bus.in_lit = 8'($urandom_range(255));
                bus.in_len = 9'($urandom_range(300));
                pend = 1'b1;
            end
            bus.in_valid = pend;
            #1;
            cur = {bus.out_err, bus.out_nbits, bus.out_code};
            if (hold) begin
                n_checks++;
                if (!bus.out_valid || cur !== held)
                    $display("FAIL stream_hold: got v/beat %b/%h want 1/%h", bus.out_valid, cur, held);
                else n_pass++;
            end
            hold = bus.out_valid && !bus.out_ready;
            held = cur;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL stream_extra_beat: got %h want none", cur);
                else begin
                    exp_v = q.pop_front();
                    if (cur !== exp_v) $display("FAIL stream_beat: got %h want %h", cur, exp_v);
                    else n_pass++;
                end
            end
            if (bus.in_valid && !bus.in_ready) stalled = 1'b1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_kind, bus.in_lit, bus.in_len));
                sent++;
                pend = 1'b0;
            end
        end
        n_checks++;
        if (cycles >= limit) $display("FAIL stream_timeout: got %0d left want 0", q.size() + n - sent);
        else n_pass++;
        if (chk_rate) begin
            n_checks++;
            if (cycles !== n + 2 || stalled)
                $display("FAIL stream_throughput: got %0d cycles stall=%b want %0d cycles stall=0",
                         cycles, stalled, n + 2);
            else n_pass++;
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_literals();
        test_lengths();
        test_full_range();
        test_errors();
        test_stall();
        test_reset_midstream();
        test_stream(40, 100, 100, 1'b1);
        test_stream(1000, 60, 75, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
